// File: rtl/dnn_batch_seq_if.sv
// ============================================================================
// dnn_batch_seq_if : src/dst stream handshake bundle for the batch sequencer
// Rev 1.0
// ============================================================================
`default_nettype none

interface dnn_batch_seq_if;
  logic src_valid;
  logic src_last;
  logic src_ready;
  logic dst_valid;
  logic dst_last;
  logic dst_ready;

  modport master (
    output src_valid, src_last, dst_ready,
    input  src_ready, dst_valid, dst_last
  );

  modport slave (
    input  src_valid, src_last, dst_ready,
    output src_ready, dst_valid, dst_last
  );
endinterface

`default_nettype wire

// File: rtl/dnn_batch_seq.sv
// ============================================================================
// dnn_batch_seq : weight/bias router and NBANK-deep src/dst sample ring control
// Rev 1.0
// ============================================================================
`default_nettype none

module dnn_batch_seq #(
  parameter int F_NUM = 16,
  parameter int NBANK = 2,
  parameter int AW    = 12,
  parameter int PW    = 10
) (
  input  wire logic                      clk,
  input  wire logic                      rst,
  input  wire logic                      run_i,
  input  wire logic                      wwrite_i,
  input  wire logic                      bwrite_i,
  input  wire logic                      last_i,
  input  wire logic [AW-1:0]             ss_i,
  input  wire logic [AW-1:0]             ds_i,
  input  wire logic [PW-1:0]             fs_i,
  dnn_batch_seq_if.slave                 strm,
  output logic                           prm_we_o,
  output logic [$clog2(F_NUM)-1:0]       prm_v_o,
  output logic [PW-1:0]                  prm_a_o,
  output logic                           src_we_o,
  output logic [$clog2(NBANK)-1:0]       src_bank_o,
  output logic [AW-1:0]                  src_a_o,
  output logic                           s_init_o,
  input  wire logic                      s_fin_i,
  output logic [$clog2(NBANK)-1:0]       exec_bank_o,
  output logic [$clog2(NBANK)-1:0]       dst_bank_o,
  output logic [AW-1:0]                  dst_a_o,
  output logic                           done_o,
  output logic                           err_o
);
  localparam int BW = $clog2(NBANK);
  localparam int VW = $clog2(F_NUM);
  localparam logic [BW:0]   C_NB    = (BW+1)'(NBANK);
  localparam logic [BW-1:0] C_LASTB = BW'(NBANK - 1);
  localparam logic [VW-1:0] C_LASTV = VW'(F_NUM - 1);

  typedef enum logic [1:0] {M_IDLE = 2'd0, M_WGT = 2'd1, M_BIAS = 2'd2, M_RUN = 2'd3} mode_t;
  typedef enum logic [0:0] {C_IDLE = 1'b0, C_BUSY = 1'b1} cst_t;

  mode_t            mode_q;
  cst_t             cst_q;
  logic             run_p_q, ww_p_q, bw_p_q;
  logic             prm_full_q, batch_loaded_q, s_init_q, done_q, err_q;
  logic [VW-1:0]    prm_v_q;
  logic [PW-1:0]    prm_a_q;
  logic [BW-1:0]    src_bank_q, exec_bank_q, dst_bank_q;
  logic [AW-1:0]    src_a_q, dst_a_q;
  logic [BW:0]      src_occ_q, dst_occ_q, src_occ_d, dst_occ_d;
  logic [NBANK-1:0] stag_q, dtag_q;

  function automatic logic [BW-1:0] f_nxt(input logic [BW-1:0] b);
    return (b == C_LASTB) ? '0 : b + 1'b1;
  endfunction

  wire logic          w_any      = run_i | wwrite_i | bwrite_i;
  wire logic          w_start    = (run_i & ~run_p_q) | (wwrite_i & ~ww_p_q) | (bwrite_i & ~bw_p_q);
  wire logic          w_prm      = ((mode_q == M_WGT) & wwrite_i) | ((mode_q == M_BIAS) & bwrite_i);
  wire logic          w_run      = (mode_q == M_RUN) & run_i;
  wire logic [PW-1:0] w_fs       = (mode_q == M_BIAS) ? '0 : fs_i;
  wire logic          w_src_rdy  = (w_prm & ~prm_full_q) |
                                   (w_run & (src_occ_q < C_NB) & ~batch_loaded_q);
  wire logic          w_src_beat = strm.src_valid & w_src_rdy;
  wire logic          w_prm_beat = w_src_beat & w_prm;
  wire logic          w_prm_end  = w_prm_beat & (prm_v_q == C_LASTV) & (prm_a_q == w_fs);
  wire logic          w_ld_beat  = w_src_beat & w_run;
  wire logic          w_ld_end   = w_ld_beat & (src_a_q == ss_i);
  // The batch tag is captured on the first word; for one-word samples it is still on last_i.
  wire logic          w_tag_cur  = (src_a_q == '0) ? last_i : stag_q[src_bank_q];
  wire logic          w_fin      = w_run & (cst_q == C_BUSY) & s_fin_i;
  wire logic          w_dst_vld  = w_run & (dst_occ_q != '0);
  wire logic          w_dst_beat = w_dst_vld & strm.dst_ready;
  wire logic          w_dst_end  = w_dst_beat & (dst_a_q == ds_i);

  always_comb begin
    src_occ_d = src_occ_q;
    dst_occ_d = dst_occ_q;
    if (w_ld_end)  src_occ_d = src_occ_d + 1'b1;
    if (w_fin) begin
      src_occ_d = src_occ_d - 1'b1;
      dst_occ_d = dst_occ_d + 1'b1;
    end
    if (w_dst_end) dst_occ_d = dst_occ_d - 1'b1;
  end

  // Issue decisions look at next-cycle occupancy so a new s_init can follow s_fin directly.
  wire logic w_issue = (src_occ_d != '0) & (dst_occ_d < C_NB);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q <= M_IDLE;  cst_q <= C_IDLE;
      run_p_q <= 1'b0;   ww_p_q <= 1'b0;   bw_p_q <= 1'b0;
      prm_full_q <= 1'b0; batch_loaded_q <= 1'b0;
      s_init_q <= 1'b0;  done_q <= 1'b0;   err_q <= 1'b0;
      prm_v_q <= '0;     prm_a_q <= '0;
      src_bank_q <= '0;  exec_bank_q <= '0; dst_bank_q <= '0;
      src_a_q <= '0;     dst_a_q <= '0;
      src_occ_q <= '0;   dst_occ_q <= '0;
      stag_q <= '0;      dtag_q <= '0;
    end else begin
      run_p_q  <= run_i;
      ww_p_q   <= wwrite_i;
      bw_p_q   <= bwrite_i;
      s_init_q <= 1'b0;
      done_q   <= 1'b0;
      if (!w_any || w_start) begin
        if (w_start) mode_q <= run_i ? M_RUN : (wwrite_i ? M_WGT : M_BIAS);
        else         mode_q <= M_IDLE;
        cst_q <= C_IDLE;
        prm_full_q <= 1'b0; batch_loaded_q <= 1'b0; err_q <= 1'b0;
        prm_v_q <= '0;     prm_a_q <= '0;
        src_bank_q <= '0;  exec_bank_q <= '0; dst_bank_q <= '0;
        src_a_q <= '0;     dst_a_q <= '0;
        src_occ_q <= '0;   dst_occ_q <= '0;
        stag_q <= '0;      dtag_q <= '0;
      end else begin
        if (w_prm_beat) begin
          if (w_prm_end) begin
            prm_full_q <= 1'b1;
            done_q     <= 1'b1;
            prm_a_q    <= '0;
            prm_v_q    <= '0;
          end else if (prm_a_q == w_fs) begin
            prm_a_q <= '0;
            prm_v_q <= prm_v_q + 1'b1;
          end else begin
            prm_a_q <= prm_a_q + 1'b1;
          end
        end

        if (w_ld_beat) begin
          if (src_a_q == '0) stag_q[src_bank_q] <= last_i;
          if (strm.src_last != (src_a_q == ss_i)) err_q <= 1'b1;
          if (w_ld_end) begin
            src_a_q    <= '0;
            src_bank_q <= f_nxt(src_bank_q);
            if (w_tag_cur) batch_loaded_q <= 1'b1;
          end else begin
            src_a_q <= src_a_q + 1'b1;
          end
        end

        case (cst_q)
          C_IDLE: begin
            if (w_run && w_issue) begin
              s_init_q <= 1'b1;
              cst_q    <= C_BUSY;
            end
          end
          C_BUSY: begin
            if (w_fin) begin
              exec_bank_q         <= f_nxt(exec_bank_q);
              dtag_q[exec_bank_q] <= stag_q[exec_bank_q];
              if (w_issue) s_init_q <= 1'b1;
              else         cst_q    <= C_IDLE;
            end
          end
          default: cst_q <= C_IDLE;
        endcase

        if (w_dst_beat) begin
          if (w_dst_end) begin
            dst_a_q    <= '0;
            dst_bank_q <= f_nxt(dst_bank_q);
            if (dtag_q[dst_bank_q]) begin
              done_q         <= 1'b1;
              batch_loaded_q <= 1'b0;
            end
          end else begin
            dst_a_q <= dst_a_q + 1'b1;
          end
        end

        src_occ_q <= src_occ_d;
        dst_occ_q <= dst_occ_d;
      end
    end
  end

  assign strm.src_ready = w_src_rdy;
  assign strm.dst_valid = w_dst_vld;
  assign strm.dst_last  = w_dst_vld & (dst_a_q == ds_i) & dtag_q[dst_bank_q];
  assign prm_we_o       = w_prm_beat;
  assign prm_v_o        = prm_v_q;
  assign prm_a_o        = prm_a_q;
  assign src_we_o       = w_ld_beat;
  assign src_bank_o     = src_bank_q;
  assign src_a_o        = src_a_q;
  assign s_init_o       = s_init_q;
  assign exec_bank_o    = exec_bank_q;
  assign dst_bank_o     = dst_bank_q;
  assign dst_a_o        = dst_a_q;
  assign done_o         = done_q;
  assign err_o          = err_q;
endmodule

`default_nettype wire

// File: tb/tb_dnn_batch_seq.sv
// ============================================================================
// tb_dnn_batch_seq : directed self-checking bench for dnn_batch_seq (F_NUM=4, NBANK=2)
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_dnn_batch_seq;
  logic clk = 1'b0;
  logic rst, run, wwrite, bwrite, last, s_fin;
  logic [3:0] ss, ds, fs;
  logic       prm_we, src_we, s_init, done, err;
  logic [1:0] prm_v;
  logic [3:0] prm_a, src_a, dst_a;
  logic       src_bank, exec_bank, dst_bank;

  int checks = 0;
  int failures = 0;
  int beats_sent, n_samp, fin_lat, fin_cd, n_init, n_dst, n_last, last_pos, n_done;

  dnn_batch_seq_if ifc ();

  dnn_batch_seq #(.F_NUM(4), .NBANK(2), .AW(4), .PW(4)) dut (
    .clk(clk), .rst(rst), .run_i(run), .wwrite_i(wwrite), .bwrite_i(bwrite), .last_i(last),
    .ss_i(ss), .ds_i(ds), .fs_i(fs), .strm(ifc),
    .prm_we_o(prm_we), .prm_v_o(prm_v), .prm_a_o(prm_a),
    .src_we_o(src_we), .src_bank_o(src_bank), .src_a_o(src_a),
    .s_init_o(s_init), .s_fin_i(s_fin), .exec_bank_o(exec_bank),
    .dst_bank_o(dst_bank), .dst_a_o(dst_a), .done_o(done), .err_o(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_counts();
    beats_sent = 0; fin_cd = 0; n_init = 0; n_dst = 0;
    n_last = 0; last_pos = 0; n_done = 0;
  endtask

  // Stream source and compute-array stand-in: 4-word samples, s_fin fin_lat cycles after s_init.
  task automatic drive();
    s_fin = 1'b0;
    if (fin_cd > 0) begin
      fin_cd--;
      if (fin_cd == 0) s_fin = 1'b1;
    end
    ifc.src_valid = (beats_sent < n_samp * 4);
    ifc.src_last  = ((beats_sent % 4) == 3);
    last          = ((beats_sent / 4) == n_samp - 1);
  endtask

  task automatic observe();
    if (ifc.src_valid && ifc.src_ready) beats_sent++;
    if (s_init) begin
      n_init++;
      fin_cd = fin_lat;
    end
    if (ifc.dst_valid && ifc.dst_ready) begin
      n_dst++;
      if (ifc.dst_last) begin
        n_last++;
        last_pos = n_dst;
      end
    end
    if (done) n_done++;
  endtask

  task automatic cyc_run(input int n);
    for (int k = 0; k < n; k++) begin
      drive();
      #1;
      observe();
      adv();
    end
  endtask

  initial begin
    rst = 1'b1; run = 0; wwrite = 0; bwrite = 0; last = 0; s_fin = 0;
    ss = 4'd3; ds = 4'd1; fs = 4'd2;
    ifc.src_valid = 0; ifc.src_last = 0; ifc.dst_ready = 0;
    n_samp = 0; fin_lat = 5;
    clr_counts();
    adv(); adv();
    chk("rst_src_ready", ifc.src_ready, 0);
    chk("rst_dst_valid", ifc.dst_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    rst = 1'b0;
    adv();

    // Weight load: 4 cores x 3 words.
    wwrite = 1'b1;
    adv();
    for (int i = 0; i < 12; i++) begin
      ifc.src_valid = 1'b1;
      #1;
      chk("ww_we", prm_we, 1);
      chk("ww_v", prm_v, i / 3);
      chk("ww_a", prm_a, i % 3);
      chk("ww_done_early", done, 0);
      adv();
    end
    #1;
    chk("ww_ready_after", ifc.src_ready, 0);
    chk("ww_we_after", prm_we, 0);
    chk("ww_done", done, 1);
    adv();
    chk("ww_done_pulse", done, 0);
    wwrite = 1'b0; ifc.src_valid = 1'b0;
    adv();
    chk("ww_idle_v", prm_v, 0);

    // Bias load: one word per core, fs ignored.
    bwrite = 1'b1;
    adv();
    for (int i = 0; i < 4; i++) begin
      ifc.src_valid = 1'b1;
      #1;
      chk("bw_a", prm_a, 0);
      chk("bw_v", prm_v, i);
      chk("bw_we", prm_we, 1);
      adv();
    end
    #1;
    chk("bw_done", done, 1);
    chk("bw_ready_after", ifc.src_ready, 0);
    adv();
    chk("bw_done_once", done, 0);
    bwrite = 1'b0; ifc.src_valid = 1'b0;
    adv();

    // Batch of 3 samples, free-running drain.
    clr_counts();
    n_samp = 3; fin_lat = 5; ifc.dst_ready = 1'b1;
    run = 1'b1;
    cyc_run(40);
    chk("run_beats", beats_sent, 12);
    chk("run_inits", n_init, 3);
    chk("run_dst_beats", n_dst, 6);
    chk("run_last_cnt", n_last, 1);
    chk("run_last_pos", last_pos, 6);
    chk("run_done_cnt", n_done, 1);
    chk("run_err", err, 0);
    chk("run_empty_valid", ifc.dst_valid, 0);
    chk("run_empty_dst_a", dst_a, 0);
    run = 1'b0;
    adv();

    // Stall: drain blocked, 4 samples offered.
    clr_counts();
    n_samp = 4; fin_lat = 5; ifc.dst_ready = 1'b0;
    run = 1'b1;
    cyc_run(40);
    chk("stall_beats", beats_sent, 16);
    chk("stall_inits", n_init, 2);
    chk("stall_src_ready", ifc.src_ready, 0);
    chk("stall_dst_valid", ifc.dst_valid, 1);
    chk("stall_dst_a", dst_a, 0);
    chk("stall_done", n_done, 0);
    ifc.dst_ready = 1'b1;
    cyc_run(60);
    chk("stall_inits_end", n_init, 4);
    chk("stall_dst_beats", n_dst, 8);
    chk("stall_last_pos", last_pos, 8);
    chk("stall_last_cnt", n_last, 1);
    chk("stall_done_end", n_done, 1);
    run = 1'b0;
    adv();

    // Premature src_last at src_a=1.
    clr_counts();
    n_samp = 0;
    run = 1'b1;
    adv();
    ifc.src_valid = 1'b1; ifc.src_last = 1'b0; last = 1'b0;
    adv();
    ifc.src_last = 1'b1;
    adv();
    ifc.src_valid = 1'b0; ifc.src_last = 1'b0;
    #1;
    chk("err_set", err, 1);
    chk("err_src_a", src_a, 2);
    adv(); adv(); adv();
    chk("err_sticky", err, 1);
    run = 1'b0;
    adv();
    chk("err_idle_clear", err, 0);

    // Final load beat coincides with s_fin.
    clr_counts();
    n_samp = 3; fin_lat = 3; ifc.dst_ready = 1'b0;
    run = 1'b1;
    cyc_run(8);
    drive();
    #1;
    chk("coinc_pre_src_bank", src_bank, 1);
    chk("coinc_pre_src_a", src_a, 3);
    chk("coinc_pre_exec", exec_bank, 0);
    chk("coinc_pre_fin", {31'd0, s_fin}, 1);
    observe();
    adv();
    drive();
    #1;
    chk("coinc_src_bank", src_bank, 0);
    chk("coinc_exec", exec_bank, 1);
    chk("coinc_s_init", s_init, 1);
    chk("coinc_src_ready", ifc.src_ready, 1);
    chk("coinc_dst_valid", ifc.dst_valid, 1);
    observe();
    adv();
    cyc_run(3);

    // Asynchronous reset mid-batch.
    rst = 1'b1;
    #1;
    chk("mid_rst_src_ready", ifc.src_ready, 0);
    chk("mid_rst_dst_valid", ifc.dst_valid, 0);
    chk("mid_rst_src_bank", src_bank, 0);
    chk("mid_rst_src_a", src_a, 0);
    chk("mid_rst_exec", exec_bank, 0);
    chk("mid_rst_s_init", s_init, 0);
    adv();
    clr_counts();
    n_samp = 0;
    rst = 1'b0;
    cyc_run(10);
    chk("post_rst_done", n_done, 0);
    chk("post_rst_inits", n_init, 0);
    chk("post_rst_err", err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule

`default_nettype wire
